// File: rtl/tamagotchi_pkg.sv
// Shared constants and types for the status frame transmitter.
package tamagotchi_pkg;

  // First byte of every status frame.
  localparam logic [7:0] SYNC_BYTE = 8'hA5;

  // Bytes per frame. The frame format fixes this value.
  localparam int FRAME_LEN = 7;

  // Index of the checksum byte, which is the last byte of the frame.
  localparam logic [2:0] LAST_IDX = 3'(FRAME_LEN - 1);

  // Bit positions inside the flag byte (b5).
  localparam int FLAG_ALERT = 0;
  localparam int FLAG_SLEEP = 1;

  // Transmitter states.
  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_e;

endpackage

// File: rtl/status_frame_tx_if.sv
// Byte-wide valid/ready link from the frame transmitter to the UART TX.
interface status_frame_tx_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  modport master (output tx_data, output tx_valid, input tx_ready);
  modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/frame_snapshot.sv
// Stat/flag latch for one frame plus the byte-select mux and XOR checksum.
// Every frame byte comes from the latched copy, so live stat changes never
// leak into a frame that is in flight.
module frame_snapshot
  import tamagotchi_pkg::*;
#(
  parameter int         STAT_W   = 5,
  parameter logic [7:0] SYNC_VAL = SYNC_BYTE
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [STAT_W-1:0] hunger,
  input  logic [STAT_W-1:0] happiness,
  input  logic [STAT_W-1:0] hygiene,
  input  logic [STAT_W-1:0] energy,
  input  logic              is_sleeping,
  input  logic [2:0]        sel,
  output logic [7:0]        byte_o
);

  logic [STAT_W-1:0] hunger_q, hunger_d;
  logic [STAT_W-1:0] happiness_q, happiness_d;
  logic [STAT_W-1:0] hygiene_q, hygiene_d;
  logic [STAT_W-1:0] energy_q, energy_d;
  logic              sleep_q, sleep_d;

  logic [7:0] hunger_b, happiness_b, hygiene_b, energy_b;
  logic [7:0] flags_b, csum_b;
  logic       alert_s;

  // Zero-extend one stat into a frame byte.
  function automatic logic [7:0] ext(input logic [STAT_W-1:0] v);
    logic [7:0] r;
    r = 8'h00;
    r[STAT_W-1:0] = v;
    return r;
  endfunction

  // Capture the live inputs when a new frame starts, otherwise hold.
  always_comb begin
    hunger_d    = hunger_q;
    happiness_d = happiness_q;
    hygiene_d   = hygiene_q;
    energy_d    = energy_q;
    sleep_d     = sleep_q;
    if (load) begin
      hunger_d    = hunger;
      happiness_d = happiness;
      hygiene_d   = hygiene;
      energy_d    = energy;
      sleep_d     = is_sleeping;
    end else begin
      sleep_d     = sleep_q;
    end
  end

  // Snapshot registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      hunger_q    <= {STAT_W{1'b0}};
      happiness_q <= {STAT_W{1'b0}};
      hygiene_q   <= {STAT_W{1'b0}};
      energy_q    <= {STAT_W{1'b0}};
      sleep_q     <= 1'b0;
    end else begin
      hunger_q    <= hunger_d;
      happiness_q <= happiness_d;
      hygiene_q   <= hygiene_d;
      energy_q    <= energy_d;
      sleep_q     <= sleep_d;
    end
  end

  // Build the frame bytes from the snapshot and select the requested one.
  always_comb begin
    hunger_b    = ext(hunger_q);
    happiness_b = ext(happiness_q);
    hygiene_b   = ext(hygiene_q);
    energy_b    = ext(energy_q);
    alert_s     = (hunger_q == {STAT_W{1'b0}}) || (happiness_q == {STAT_W{1'b0}}) ||
                  (hygiene_q == {STAT_W{1'b0}}) || (energy_q == {STAT_W{1'b0}});
    flags_b             = 8'h00;
    flags_b[FLAG_ALERT] = alert_s;
    flags_b[FLAG_SLEEP] = sleep_q;
    csum_b = SYNC_VAL ^ hunger_b ^ happiness_b ^ hygiene_b ^ energy_b ^ flags_b;
    case (sel)
      3'd0:    byte_o = SYNC_VAL;
      3'd1:    byte_o = hunger_b;
      3'd2:    byte_o = happiness_b;
      3'd3:    byte_o = hygiene_b;
      3'd4:    byte_o = energy_b;
      3'd5:    byte_o = flags_b;
      3'd6:    byte_o = csum_b;
      default: byte_o = 8'h00;
    endcase
  end

endmodule

// File: rtl/status_frame_tx.sv
// Status frame transmitter: on a one-second tick or a host request it
// snapshots the stats and streams a 7-byte frame over a valid/ready link.
// One trigger can be held pending while a frame is in flight; further
// triggers are dropped and flagged through the sticky overrun bit.
module status_frame_tx
  import tamagotchi_pkg::*;
#(
  parameter int         STAT_W   = 5,
  parameter logic [7:0] SYNC_VAL = SYNC_BYTE
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                second,
  input  logic                req,
  input  logic [STAT_W-1:0]   hunger,
  input  logic [STAT_W-1:0]   happiness,
  input  logic [STAT_W-1:0]   hygiene,
  input  logic [STAT_W-1:0]   energy,
  input  logic                is_sleeping,
  status_frame_tx_if.master   tx,
  output logic                busy,
  output logic [7:0]          frame_count,
  output logic                overrun
);

  state_e     state_q, state_d;
  logic [2:0] idx_q, idx_d;
  logic       pending_q, pending_d;
  logic       overrun_q, overrun_d;
  logic [7:0] count_q, count_d;
  logic       valid_q, valid_d;
  logic [7:0] data_q, data_d;
  logic       busy_q, busy_d;

  logic       trig_s;
  logic       xfer_s;
  logic       load_s;
  logic [2:0] next_idx_s;
  logic [7:0] next_byte_s;

  assign trig_s     = second | req;
  assign xfer_s     = valid_q & tx.tx_ready;
  assign next_idx_s = idx_q + 3'd1;

  frame_snapshot #(
    .STAT_W   (STAT_W),
    .SYNC_VAL (SYNC_VAL)
  ) u_snap (
    .clk         (clk),
    .reset       (reset),
    .load        (load_s),
    .hunger      (hunger),
    .happiness   (happiness),
    .hygiene     (hygiene),
    .energy      (energy),
    .is_sleeping (is_sleeping),
    .sel         (next_idx_s),
    .byte_o      (next_byte_s)
  );

  // Next-state, pending/overrun bookkeeping and registered output values.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    pending_d = pending_q;
    overrun_d = overrun_q;
    count_d   = count_q;
    valid_d   = valid_q;
    data_d    = data_q;
    busy_d    = busy_q;
    load_s    = 1'b0;
    case (state_q)
      IDLE: begin
        if (trig_s) begin
          load_s  = 1'b1;
          state_d = SEND;
          idx_d   = 3'd0;
          valid_d = 1'b1;
          data_d  = SYNC_VAL;
          busy_d  = 1'b1;
        end else begin
          valid_d = 1'b0;
          busy_d  = 1'b0;
        end
      end
      SEND: begin
        if (xfer_s && (idx_q == LAST_IDX)) begin
          count_d = count_q + 8'd1;
          // A held trigger, or one arriving on this edge, chains the next
          // frame with no idle cycle; both at once means one was lost.
          if (pending_q || trig_s) begin
            load_s    = 1'b1;
            idx_d     = 3'd0;
            data_d    = SYNC_VAL;
            pending_d = 1'b0;
            if (pending_q && trig_s) begin
              overrun_d = 1'b1;
            end else begin
              overrun_d = overrun_q;
            end
          end else begin
            state_d   = IDLE;
            idx_d     = 3'd0;
            valid_d   = 1'b0;
            busy_d    = 1'b0;
            pending_d = 1'b0;
          end
        end else begin
          if (xfer_s) begin
            idx_d  = next_idx_s;
            data_d = next_byte_s;
          end else begin
            idx_d  = idx_q;
          end
          if (trig_s) begin
            if (pending_q) begin
              overrun_d = 1'b1;
            end else begin
              pending_d = 1'b1;
            end
          end else begin
            pending_d = pending_q;
          end
        end
      end
      default: begin
        state_d   = IDLE;
        idx_d     = 3'd0;
        valid_d   = 1'b0;
        busy_d    = 1'b0;
        pending_d = 1'b0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      idx_q     <= 3'd0;
      pending_q <= 1'b0;
      overrun_q <= 1'b0;
      count_q   <= 8'd0;
      valid_q   <= 1'b0;
      data_q    <= 8'h00;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      pending_q <= pending_d;
      overrun_q <= overrun_d;
      count_q   <= count_d;
      valid_q   <= valid_d;
      data_q    <= data_d;
      busy_q    <= busy_d;
    end
  end

  assign tx.tx_data   = data_q;
  assign tx.tx_valid  = valid_q;
  assign busy         = busy_q;
  assign frame_count  = count_q;
  assign overrun      = overrun_q;

endmodule

// File: tb/tb_status_frame_tx.sv
// Self-checking bench for status_frame_tx: directed scenarios followed by
// randomized traffic, all checked against a byte-queue reference model.
module tb_status_frame_tx;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       second = 1'b0;
  logic       req = 1'b0;
  logic [4:0] h = 5'd0, ha = 5'd0, hy = 5'd0, e = 5'd0;
  logic       sl = 1'b0;
  logic       busy;
  logic [7:0] frame_count;
  logic       overrun;

  status_frame_tx_if txif ();

  status_frame_tx #(.STAT_W(5)) dut (
    .clk         (clk),
    .reset       (reset),
    .second      (second),
    .req         (req),
    .hunger      (h),
    .happiness   (ha),
    .hygiene     (hy),
    .energy      (e),
    .is_sleeping (sl),
    .tx          (txif),
    .busy        (busy),
    .frame_count (frame_count),
    .overrun     (overrun)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference model: remaining bytes of the frame in flight, one-deep
  // pending flag, sticky overrun, completed frame count.
  logic [7:0] cur[$];
  bit         m_pend = 1'b0;
  bit         m_ovr = 1'b0;
  int         m_cnt = 0;
  logic [7:0] got[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Append a complete frame built from the current live stat values.
  function automatic void load_frame();
    logic [7:0] b[7];
    b[0] = 8'hA5;
    b[1] = {3'b000, h};
    b[2] = {3'b000, ha};
    b[3] = {3'b000, hy};
    b[4] = {3'b000, e};
    b[5] = (sl ? 8'd2 : 8'd0) |
           ((h == 5'd0 || ha == 5'd0 || hy == 5'd0 || e == 5'd0) ? 8'd1 : 8'd0);
    b[6] = b[0] ^ b[1] ^ b[2] ^ b[3] ^ b[4] ^ b[5];
    for (int i = 0; i < 7; i++) cur.push_back(b[i]);
  endfunction

  // One clock: drive inputs, advance the model across the edge, compare.
  task automatic step(input bit sec, input bit rq, input bit rdy);
    bit trig;
    bit fin;
    second = sec;
    req = rq;
    txif.tx_ready = rdy;
    trig = sec | rq;
    if (txif.tx_valid && rdy && !reset) got.push_back(txif.tx_data);
    if (reset) begin
      cur.delete();
      m_pend = 1'b0;
      m_ovr = 1'b0;
      m_cnt = 0;
    end else if (cur.size() > 0) begin
      fin = rdy && (cur.size() == 1);
      if (rdy) void'(cur.pop_front());
      if (fin) begin
        m_cnt = (m_cnt + 1) % 256;
        if (m_pend) begin
          load_frame();
          m_pend = 1'b0;
          if (trig) m_ovr = 1'b1;
        end else if (trig) begin
          load_frame();
        end
      end else if (trig) begin
        if (m_pend) m_ovr = 1'b1;
        else m_pend = 1'b1;
      end
    end else if (trig) begin
      load_frame();
    end
    @(posedge clk);
    #1;
    second = 1'b0;
    req = 1'b0;
    chk("tx_valid", {31'd0, txif.tx_valid}, {31'd0, cur.size() > 0});
    chk("busy", {31'd0, busy}, {31'd0, cur.size() > 0});
    if (cur.size() > 0) chk("tx_data", {24'd0, txif.tx_data}, {24'd0, cur[0]});
    chk("frame_count", {24'd0, frame_count}, m_cnt);
    chk("overrun", {31'd0, overrun}, {31'd0, m_ovr});
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b1);
    reset = 1'b0;
  endtask

  initial begin
    logic [7:0] exp1[7];
    bit pat[4];
    int base;
    txif.tx_ready = 1'b0;
    exp1[0] = 8'hA5; exp1[1] = 8'h0A; exp1[2] = 8'h14; exp1[3] = 8'h05;
    exp1[4] = 8'h1F; exp1[5] = 8'h00; exp1[6] = 8'hA1;
    pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0; pat[3] = 1'b1;

    // Reset state.
    do_reset();
    chk("reset_tx_data", {24'd0, txif.tx_data}, 32'h0);

    // Basic frame with ready held high.
    h = 5'd10; ha = 5'd20; hy = 5'd5; e = 5'd31; sl = 1'b0;
    got.delete();
    step(1'b1, 1'b0, 1'b1);
    repeat (8) step(1'b0, 1'b0, 1'b1);
    chk("basic_len", got.size(), 32'd7);
    for (int i = 0; i < 7; i++) chk("basic_byte", {24'd0, got[i]}, {24'd0, exp1[i]});

    // Stalled frame; hunger drops to zero mid-frame.
    got.delete();
    step(1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 20; i++) begin
      if (i == 3) h = 5'd0;
      step(1'b0, 1'b0, pat[i % 4]);
    end
    step(1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 20; i++) step(1'b0, 1'b0, pat[i % 4]);
    chk("stall_len", got.size(), 32'd14);
    chk("stall_b1_snapshot", {24'd0, got[1]}, 32'h0A);
    chk("next_b5_alert", {24'd0, got[12]}, 32'h01);

    // Request during byte 3 chains a second frame with no gap.
    h = 5'd7;
    base = m_cnt;
    step(1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b1);
    repeat (14) step(1'b0, 1'b0, 1'b1);
    chk("chain_count", {24'd0, frame_count}, (base + 2) % 256);
    chk("chain_no_overrun", {31'd0, overrun}, 32'd0);

    // Three triggers in one frame: two frames, overrun set.
    base = m_cnt;
    step(1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b1);
    repeat (16) step(1'b0, 1'b0, 1'b1);
    chk("ovr_count", {24'd0, frame_count}, (base + 2) % 256);
    chk("ovr_flag", {31'd0, overrun}, 32'd1);

    // Reset in the middle of a frame at byte index 4.
    do_reset();
    step(1'b1, 1'b0, 1'b1);
    repeat (4) step(1'b0, 1'b0, 1'b1);
    reset = 1'b1;
    step(1'b0, 1'b0, 1'b1);
    reset = 1'b0;
    chk("midreset_valid", {31'd0, txif.tx_valid}, 32'd0);
    chk("midreset_count", {24'd0, frame_count}, 32'd0);
    got.delete();
    step(1'b1, 1'b0, 1'b1);
    repeat (8) step(1'b0, 1'b0, 1'b1);
    chk("after_reset_len", got.size(), 32'd7);
    chk("after_reset_b0", {24'd0, got[0]}, 32'hA5);

    // 256 frames wrap the counter; then simultaneous triggers in IDLE.
    do_reset();
    for (int f = 0; f < 256; f++) begin
      step(1'b1, 1'b0, 1'b1);
      repeat (7) step(1'b0, 1'b0, 1'b1);
    end
    step(1'b0, 1'b0, 1'b1);
    chk("wrap_count", {24'd0, frame_count}, 32'd0);
    step(1'b1, 1'b1, 1'b1);
    repeat (10) step(1'b0, 1'b0, 1'b1);
    chk("dual_trig_count", {24'd0, frame_count}, 32'd1);
    chk("dual_trig_ovr", {31'd0, overrun}, 32'd0);

    // Randomized traffic.
    for (int c = 0; c < 3000; c++) begin
      h  = 5'($urandom_range(0, 31));
      ha = 5'($urandom_range(0, 31));
      hy = 5'($urandom_range(0, 31));
      e  = 5'($urandom_range(0, 31));
      sl = 1'($urandom_range(0, 1));
      reset = ($urandom_range(0, 299) == 0);
      step($urandom_range(0, 11) == 0, $urandom_range(0, 13) == 0,
           $urandom_range(0, 3) != 0);
      reset = 1'b0;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
